// File: rtl/digit_entry_decoder_pkg.sv
// Shared types and widths for the decimal-entry front end, display path and game controller.
package digit_entry_decoder_pkg;

   localparam int DEFAULT_NUM_DIGITS  = 4;
   localparam int DEFAULT_VALUE_WIDTH = 13;
   localparam logic [3:0] BCD_MAX     = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } entry_state_e;

   // Counter must reach NUM_DIGITS inclusive, hence the +1.
   function automatic int count_width(input int num_digits);
      return $clog2(num_digits + 1);
   endfunction

endpackage

// File: rtl/digit_entry_decoder_if.sv
// Keypad-side bundle: digit/enter/clear strobes in, committed value and per-digit echo out.
interface digit_entry_decoder_if
   import digit_entry_decoder_pkg::*;
#(
   parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
   parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
);
   localparam int CNT_W = count_width(NUM_DIGITS);

   logic [3:0]              digit_in;
   logic                    digit_valid;
   logic                    enter;
   logic                    clear;
   logic [VALUE_WIDTH-1:0]  value;
   logic                    done;
   logic                    overflow;
   logic                    digit_error;
   logic [CNT_W-1:0]        digit_count;
   logic [4*NUM_DIGITS-1:0] echo;

   modport master (
      output digit_in, digit_valid, enter, clear,
      input  value, done, overflow, digit_error, digit_count, echo
   );

   modport slave (
      input  digit_in, digit_valid, enter, clear,
      output value, done, overflow, digit_error, digit_count, echo
   );

endinterface

// File: rtl/digit_entry_decoder_bcd_mac_x10.sv
// Combinational decimal shift-in step: result = acc*10 + digit, shift-add form.
module bcd_mac_x10 #(
   parameter int W = 14
) (
   input  logic [W-1:0] acc,
   input  logic [3:0]   digit,
   output logic [W-1:0] result
);

   assign result = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/digit_entry_decoder.sv
// Accumulates MSB-first BCD digits into a saturating binary value with a display echo.
module digit_entry_decoder
   import digit_entry_decoder_pkg::*;
#(
   parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
   parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   digit_entry_decoder_if.slave bus
);

   localparam int ACC_W  = VALUE_WIDTH + 1;
   localparam int CNT_W  = count_width(NUM_DIGITS);
   localparam int ECHO_W = 4 * NUM_DIGITS;
   localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'((1 << VALUE_WIDTH) - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(NUM_DIGITS);

   entry_state_e           state;
   logic [ACC_W-1:0]       acc;
   logic [ACC_W-1:0]       acc_src;
   logic [ACC_W-1:0]       acc_next;
   logic [CNT_W-1:0]       cnt;
   logic [ECHO_W-1:0]      echo;
   logic [VALUE_WIDTH-1:0] value;
   logic                   done;
   logic                   overflow;
   logic                   digit_error;

   // A digit after a commit starts a fresh entry, so the MAC sees zero.
   assign acc_src = (state == ST_DONE) ? '0 : acc;

   bcd_mac_x10 #(.W(ACC_W)) u_mac (
      .acc    (acc_src),
      .digit  (bus.digit_in),
      .result (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         cnt         <= '0;
         echo        <= '0;
         value       <= '0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         digit_error <= 1'b0;
      end else begin
         done        <= 1'b0;
         digit_error <= 1'b0;
         if (bus.clear) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            echo  <= '0;
         end else if (bus.enter) begin
            case (state)
               ST_IDLE: begin
                  value    <= '0;
                  overflow <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end
               ST_COLLECT: begin
                  if (acc > SAT_LIMIT) begin
                     value    <= '1;
                     overflow <= 1'b1;
                  end else begin
                     value    <= acc[VALUE_WIDTH-1:0];
                     overflow <= 1'b0;
                  end
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
               default: ;
            endcase
         end else if (bus.digit_valid) begin
            if (bus.digit_in > BCD_MAX) begin
               digit_error <= 1'b1;
            end else if (state == ST_DONE) begin
               acc      <= acc_next;
               cnt      <= CNT_W'(1);
               echo     <= ECHO_W'(bus.digit_in);
               overflow <= 1'b0;
               state    <= ST_COLLECT;
            end else if (cnt < MAX_CNT) begin
               // Full entries drop extra digits silently.
               acc   <= acc_next;
               cnt   <= cnt + CNT_W'(1);
               echo  <= {echo[ECHO_W-5:0], bus.digit_in};
               state <= ST_COLLECT;
            end
         end
      end
   end

   assign bus.value       = value;
   assign bus.done        = done;
   assign bus.overflow    = overflow;
   assign bus.digit_error = digit_error;
   assign bus.digit_count = cnt;
   assign bus.echo        = echo;

endmodule

// File: tb/tb_digit_entry_decoder.sv
// Directed self-checking bench for digit_entry_decoder.
module tb_digit_entry_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   fails = 0;

   digit_entry_decoder_if #(.NUM_DIGITS(4), .VALUE_WIDTH(13)) bus ();

   digit_entry_decoder #(.NUM_DIGITS(4), .VALUE_WIDTH(13)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; outputs are sampled 1ns after the edge.
   task automatic step(input logic dv, input logic [3:0] d, input logic en, input logic cl);
      @(negedge clk);
      bus.digit_valid = dv;
      bus.digit_in    = d;
      bus.enter       = en;
      bus.clear       = cl;
      @(posedge clk);
      #1;
      bus.digit_valid = 1'b0;
      bus.digit_in    = 4'd0;
      bus.enter       = 1'b0;
      bus.clear       = 1'b0;
   endtask

   task automatic digit(input logic [3:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic enter();
      step(1'b0, 4'd0, 1'b1, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.digit_valid = 1'b0;
      bus.digit_in    = 4'd0;
      bus.enter       = 1'b0;
      bus.clear       = 1'b0;

      rst = 1'b1;
      idle();
      idle();
      chk("rst_value", 32'(bus.value), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_err", 32'(bus.digit_error), 0);
      chk("rst_cnt", 32'(bus.digit_count), 0);
      chk("rst_echo", 32'(bus.echo), 0);
      rst = 1'b0;

      // 4,2,0,7 then Enter
      digit(4'd4);
      chk("t1_cnt1", 32'(bus.digit_count), 1);
      digit(4'd2);
      digit(4'd0);
      digit(4'd7);
      chk("t1_echo", 32'(bus.echo), 32'h4207);
      chk("t1_cnt", 32'(bus.digit_count), 4);
      chk("t1_done_pre", 32'(bus.done), 0);
      enter();
      chk("t1_value", 32'(bus.value), 4207);
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_ovf", 32'(bus.overflow), 0);
      chk("t1_echo_held", 32'(bus.echo), 32'h4207);
      idle();
      chk("t1_done_1cyc", 32'(bus.done), 0);

      // 9999 saturates, next entry clears Overflow
      digit(4'd9);
      chk("t2_restart_cnt", 32'(bus.digit_count), 1);
      chk("t2_restart_echo", 32'(bus.echo), 32'h0009);
      digit(4'd9);
      digit(4'd9);
      digit(4'd9);
      enter();
      chk("t2_value_sat", 32'(bus.value), 8191);
      chk("t2_ovf", 32'(bus.overflow), 1);
      chk("t2_done", 32'(bus.done), 1);
      digit(4'd5);
      chk("t2_ovf_clr", 32'(bus.overflow), 0);
      chk("t2_value_hold", 32'(bus.value), 8191);
      chk("t2_echo5", 32'(bus.echo), 32'h0005);
      enter();
      chk("t2_value5", 32'(bus.value), 5);
      chk("t2_ovf5", 32'(bus.overflow), 0);

      // invalid digit rejected
      digit(4'd1);
      digit(4'd12);
      chk("t3_err", 32'(bus.digit_error), 1);
      chk("t3_cnt_hold", 32'(bus.digit_count), 1);
      chk("t3_echo_hold", 32'(bus.echo), 32'h0001);
      digit(4'd3);
      chk("t3_err_1cyc", 32'(bus.digit_error), 0);
      enter();
      chk("t3_value", 32'(bus.value), 13);
      chk("t3_cnt", 32'(bus.digit_count), 2);

      // fifth digit dropped, second Enter ignored
      digit(4'd1);
      digit(4'd2);
      digit(4'd3);
      digit(4'd4);
      digit(4'd5);
      chk("t4_cnt", 32'(bus.digit_count), 4);
      chk("t4_echo", 32'(bus.echo), 32'h1234);
      chk("t4_no_err", 32'(bus.digit_error), 0);
      enter();
      chk("t4_value", 32'(bus.value), 1234);
      chk("t4_done", 32'(bus.done), 1);
      enter();
      chk("t4_done_ignored", 32'(bus.done), 0);
      chk("t4_value_hold", 32'(bus.value), 1234);

      // Clear then Enter in IDLE commits zero
      digit(4'd7);
      digit(4'd7);
      step(1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5_clr_cnt", 32'(bus.digit_count), 0);
      chk("t5_clr_echo", 32'(bus.echo), 0);
      chk("t5_clr_value", 32'(bus.value), 1234);
      enter();
      chk("t5_value0", 32'(bus.value), 0);
      chk("t5_done0", 32'(bus.done), 1);

      // Enter beats a coincident digit
      digit(4'd8);
      step(1'b1, 4'd3, 1'b1, 1'b0);
      chk("t5_value8", 32'(bus.value), 8);
      chk("t5_echo8", 32'(bus.echo), 32'h0008);
      chk("t5_cnt8", 32'(bus.digit_count), 1);

      // Clear beats a coincident Enter
      digit(4'd6);
      step(1'b0, 4'd0, 1'b1, 1'b1);
      chk("t5_clr_pri_done", 32'(bus.done), 0);
      chk("t5_clr_pri_value", 32'(bus.value), 8);

      // Reset mid-entry
      digit(4'd6);
      digit(4'd5);
      chk("t6_cnt_pre", 32'(bus.digit_count), 2);
      rst = 1'b1;
      idle();
      chk("t6_value", 32'(bus.value), 0);
      chk("t6_done", 32'(bus.done), 0);
      chk("t6_cnt", 32'(bus.digit_count), 0);
      chk("t6_echo", 32'(bus.echo), 0);
      chk("t6_ovf", 32'(bus.overflow), 0);
      rst = 1'b0;
      // Enter only pulses Done from IDLE or COLLECT, so this confirms IDLE
      enter();
      chk("t6_idle_done", 32'(bus.done), 1);
      chk("t6_idle_value", 32'(bus.value), 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
